result_demux_1to3: RTL and testbench
====================================

# result_demux_1to3

Buffered 1-to-3 demultiplexer for the datapath. It accepts a 32-bit result tagged with a 2-bit destination select over a valid/ready handshake, and delivers it in order to exactly one of three destination ports (A, B, C), each with its own valid/ready. A two-entry in-order buffer decouples producer and consumers, so a stalled destination back-pressures the producer without losing data. The select encoding matches the datapath 3-to-1 select convention: 00=A, 01=B, 10=C.

## Interface
- WIDTH, 32, data width of the result and of every output port

- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- inData  input  WIDTH  result to be routed
- inSel  input  2  destination: 00=A, 01=B, 10=C, 11=illegal
- inValid  input  1  producer has a beat on inData/inSel
- inReady  output  1  block can accept a beat this cycle
- outA, outB, outC  output  WIDTH  per-destination data
- validA, validB, validC  output  1  per-destination beat present
- readyA, readyB, readyC  input  1  destination consumes the beat
- dropCount  output  8  saturating count of illegal-select beats

## Operation
- Storage: 2-entry FIFO of {sel, data}; occupancy count 0..2.
- Accept: a beat transfers when inValid && inReady.
  - Legal sel: pushed to the FIFO tail.
  - sel=11: not stored, and dropCount increments (saturates at 255).
- inReady = (count != 2). It depends only on registered state and has no combinational path from inValid or the ready inputs.
- Head presentation: when count>0, only the valid of the head's sel port is 1, and that port's data equals the head data. Every other valid is 0 and every other data output is 0. When count=0, all valids and data outputs are 0.
- Pop: the head is popped when the selected port's valid && ready. Ready inputs of non-selected ports are ignored.
- Ordering: strict FIFO across all destinations. A stalled head blocks later beats for other ports (no reordering).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. The new beat enters behind the surviving entry, or becomes the head if the popped entry was the only one.
  - Illegal beat with a pop in the same cycle: count decrements, and dropCount increments.
- Holding: while valid && !ready, the port's data and valid are stable.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count=0, inReady=1.
  - All valids and all out data = 0.
  - dropCount=0.
  - The FIFO contents become don't-care but are never presented.
- Latency: a beat accepted at edge N is presented on its port after edge N (visible in cycle N+1) if the FIFO was empty. Otherwise it is presented once all earlier entries pop.
- Throughput: one beat per cycle sustained when the head's destination ready is held high.
- Full: at count=2, inReady=0 from that cycle on. It returns to 1 the cycle after a pop.
- Reset mid-operation: buffered beats are discarded, and no valid is asserted in the cycle after reset releases. The drop counter clears.
- dropCount updates on the accepting edge and is visible the following cycle.

## Structure
- Package result_demux_pkg: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_BAD=2'b11, and DROP_MAX=8'd255.
- Sub-module sel_data_fifo2: a 2-entry FIFO with push/pop/count/head outputs, parameterized on payload width (WIDTH+2).
- Top level contents: accept logic, illegal-select filtering, head decode to the three ports, pop selection, and the drop counter.

## Test plan
- Route each destination: send 0x11111111/sel 00, 0x22222222/sel 01, 0x33333333/sel 10 with all readies high. Each appears only on A, B, C respectively, one cycle after acceptance; other ports show valid=0, data=0.
- Back-pressure: readyB=0, send three sel-01 beats. Two are accepted, then inReady=0; validB holds with stable data 0xAAAA0001. Raising readyB drains 0xAAAA0001 then 0xAAAA0002, and the third beat is accepted once inReady returns to 1.
- Head-of-line ordering: readyA=0, send sel 00 then sel 10. validC stays 0 until the A beat pops, then C delivers its data.
- Illegal select: 300 beats with sel=11. None is presented, inReady stays 1, and dropCount reads 255 (saturated).
- Simultaneous push/pop: with count=1 and readyA=1, push a sel-00 beat in the same cycle as the pop. count stays 1 and back-to-back beats appear on A with no bubble.
- Async reset mid-stream: with count=2 and validC=1, pulse Rst between clock edges. All outputs go 0 and inReady goes 1 immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/result_demux_pkg.sv
// Shared select encoding and limits for the 1-to-3 result demultiplexer.
package result_demux_pkg;

   typedef enum logic [1:0] {
      SEL_A   = 2'b00,
      SEL_B   = 2'b01,
      SEL_C   = 2'b10,
      SEL_BAD = 2'b11
   } sel_e;

   localparam int unsigned SEL_W    = 2;
   localparam logic [7:0]  DROP_MAX = 8'd255;

   // A beat is routable unless it carries the reserved select code.
   function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
      return sel != SEL_BAD;
   endfunction

endpackage

// File: rtl/sel_data_fifo2.sv
// Two-entry in-order FIFO holding {sel, data} payloads for the demux.
module sel_data_fifo2 #(
   parameter int unsigned PW = 34
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [PW-1:0] pushData_i,
   output logic [1:0]    count_o,
   output logic [PW-1:0] headData_o,
   output logic          empty_o
);

   logic [PW-1:0] mem_q [2];
   logic          wrPtr_q, wrPtr_d;
   logic          rdPtr_q, rdPtr_d;
   logic [1:0]    count_q, count_d;
   logic          doPush, doPop;

   // Guard against overflow/underflow so the pointers can never desynchronise.
   always_comb begin
      doPush  = push_i && (count_q != 2'd2);
      doPop   = pop_i && (count_q != 2'd0);
      wrPtr_d = doPush ? ~wrPtr_q : wrPtr_q;
      rdPtr_d = doPop  ? ~rdPtr_q : rdPtr_q;
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state, cleared immediately on reset.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Payload storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge Clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   assign count_o    = count_q;
   assign headData_o = mem_q[rdPtr_q];
   assign empty_o    = (count_q == 2'd0);

endmodule

// File: rtl/result_demux_1to3.sv
// Buffered 1-to-3 result demultiplexer: filters illegal selects, buffers two
// beats in order and presents the head beat on exactly one destination port.
module result_demux_1to3 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] inData,
   input  logic [1:0]       inSel,
   input  logic             inValid,
   output logic             inReady,
   output logic [WIDTH-1:0] outA,
   output logic [WIDTH-1:0] outB,
   output logic [WIDTH-1:0] outC,
   output logic             validA,
   output logic             validB,
   output logic             validC,
   input  logic             readyA,
   input  logic             readyB,
   input  logic             readyC,
   output logic [7:0]       dropCount
);

   import result_demux_pkg::*;

   localparam int unsigned PW = WIDTH + SEL_W;

   logic             accept;
   logic             legal;
   logic             push;
   logic             pop;
   logic [1:0]       fifoCount;
   logic             fifoEmpty;
   logic [PW-1:0]    headPayload;
   logic [1:0]       headSel;
   logic [WIDTH-1:0] headData;
   logic [7:0]       dropCount_q, dropCount_d;

   sel_data_fifo2 #(
      .PW(PW)
   ) u_fifo (
      .Clk        (Clk),
      .Rst        (Rst),
      .push_i     (push),
      .pop_i      (pop),
      .pushData_i ({inSel, inData}),
      .count_o    (fifoCount),
      .headData_o (headPayload),
      .empty_o    (fifoEmpty)
   );

   assign headSel  = headPayload[PW-1:WIDTH];
   assign headData = headPayload[WIDTH-1:0];

   // Accept/filter: ready comes only from registered occupancy; illegal beats are consumed but not stored.
   always_comb begin
      inReady = (fifoCount != 2'd2);
      accept  = inValid && inReady;
      legal   = sel_is_legal(inSel);
      push    = accept && legal;
   end

   // Head decode: only the selected port sees valid and data, all others read zero.
   always_comb begin
      validA = !fifoEmpty && (headSel == SEL_A);
      validB = !fifoEmpty && (headSel == SEL_B);
      validC = !fifoEmpty && (headSel == SEL_C);
      outA   = validA ? headData : '0;
      outB   = validB ? headData : '0;
      outC   = validC ? headData : '0;
      pop    = (validA && readyA) || (validB && readyB) || (validC && readyC);
   end

   // Saturating drop counter next state.
   always_comb begin
      dropCount_d = dropCount_q;
      if (accept && !legal && (dropCount_q != DROP_MAX)) begin
         dropCount_d = dropCount_q + 8'd1;
      end
   end

   // Drop counter register, cleared asynchronously.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         dropCount_q <= '0;
      end else begin
         dropCount_q <= dropCount_d;
      end
   end

   assign dropCount = dropCount_q;

endmodule

// File: tb/tb_result_demux_1to3.sv
// Self-checking bench for result_demux_1to3: routing table, back-pressure,
// head-of-line ordering, illegal-select saturation, push/pop overlap, async reset.
module tb_result_demux_1to3;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] inData;
   logic [1:0]  inSel;
   logic        inValid;
   logic        inReady;
   logic [31:0] outA, outB, outC;
   logic        validA, validB, validC;
   logic        readyA, readyB, readyC;
   logic [7:0]  dropCount;

   always #5 Clk = ~Clk;

   result_demux_1to3 #(
      .WIDTH(32)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .inData    (inData),
      .inSel     (inSel),
      .inValid   (inValid),
      .inReady   (inReady),
      .outA      (outA),
      .outB      (outB),
      .outC      (outC),
      .validA    (validA),
      .validB    (validB),
      .validC    (validC),
      .readyA    (readyA),
      .readyB    (readyB),
      .readyC    (readyC),
      .dropCount (dropCount)
   );

   typedef struct {
      logic [1:0]  port;
      logic [31:0] data;
   } sb_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] data;
      logic [2:0]  expV;   // {C,B,A}
   } vec_t;

   sb_t sb[$];
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input logic [1:0] p, input logic [31:0] d);
      sb_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_beat: actual port=%0d data=%h required=no beat", p, d);
      end else begin
         e = sb.pop_front();
         chk("pop_port", {30'd0, p}, {30'd0, e.port});
         chk("pop_data", d, e.data);
      end
   endtask

   // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
   always @(negedge Clk) begin
      if (!Rst) begin
         chk("onehot", (({2'b0, validA} + {2'b0, validB} + {2'b0, validC}) > 3'd1) ? 32'd1 : 32'd0, 32'd0);
         if (!validA) chk("idleA_zero", outA, 32'd0);
         if (!validB) chk("idleB_zero", outB, 32'd0);
         if (!validC) chk("idleC_zero", outC, 32'd0);
         if (validA && readyA) pop_chk(2'd0, outA);
         if (validB && readyB) pop_chk(2'd1, outB);
         if (validC && readyC) pop_chk(2'd2, outC);
      end
   end

   // Drives one beat and holds it until accepted (bounded); returns 1 time unit after the accepting edge.
   task automatic send(input logic [1:0] s, input logic [31:0] d);
      bit done;
      done    = 1'b0;
      inValid = 1'b1;
      inSel   = s;
      inData  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge Clk);
         if (inReady) begin
            if (s != 2'b11) sb.push_back('{s, d});
            done = 1'b1;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: actual inReady=0 required=1 within 50 cycles");
      end
      @(posedge Clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0) break;
         @(posedge Clk);
         #1;
      end
      chk("drain_empty", sb.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      logic [31:0] prevB;

      tbl[0] = '{2'b00, 32'h1111_1111, 3'b001};
      tbl[1] = '{2'b01, 32'h2222_2222, 3'b010};
      tbl[2] = '{2'b10, 32'h3333_3333, 3'b100};
      tbl[3] = '{2'b00, 32'hFFFF_FFFF, 3'b001};
      tbl[4] = '{2'b10, 32'h0000_0001, 3'b100};

      Rst     = 1'b1;
      inValid = 1'b0;
      inSel   = 2'b00;
      inData  = '0;
      readyA  = 1'b1;
      readyB  = 1'b1;
      readyC  = 1'b1;

      // Reset state
      #2;
      chk("rst_inReady", {31'd0, inReady}, 32'd1);
      chk("rst_valids", {29'd0, validC, validB, validA}, 32'd0);
      chk("rst_dropCount", {24'd0, dropCount}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      @(posedge Clk);
      #1;

      // Routing table: one beat per cycle, all readies high
      foreach (tbl[k]) begin
         inValid = 1'b1;
         inSel   = tbl[k].sel;
         inData  = tbl[k].data;
         chk("tbl_inReady", {31'd0, inReady}, 32'd1);
         sb.push_back('{tbl[k].sel, tbl[k].data});
         @(posedge Clk);
         #1;
         inValid = 1'b0;
         chk("tbl_validA", {31'd0, validA}, {31'd0, tbl[k].expV[0]});
         chk("tbl_validB", {31'd0, validB}, {31'd0, tbl[k].expV[1]});
         chk("tbl_validC", {31'd0, validC}, {31'd0, tbl[k].expV[2]});
         chk("tbl_outA", outA, tbl[k].expV[0] ? tbl[k].data : 32'd0);
         chk("tbl_outB", outB, tbl[k].expV[1] ? tbl[k].data : 32'd0);
         chk("tbl_outC", outC, tbl[k].expV[2] ? tbl[k].data : 32'd0);
      end
      drain();

      // Back-pressure on B: two beats fill the buffer, third waits
      readyB = 1'b0;
      send(2'b01, 32'hAAAA_0001);
      send(2'b01, 32'hAAAA_0002);
      chk("bp_full_inReady", {31'd0, inReady}, 32'd0);
      chk("bp_validB", {31'd0, validB}, 32'd1);
      chk("bp_outB", outB, 32'hAAAA_0001);
      prevB = outB;
      fork
         send(2'b01, 32'hAAAA_0003);
         begin
            repeat (3) begin
               @(posedge Clk);
               #1;
               chk("bp_hold_validB", {31'd0, validB}, 32'd1);
               chk("bp_hold_outB", outB, prevB);
               chk("bp_hold_inReady", {31'd0, inReady}, 32'd0);
            end
            readyB = 1'b1;
            @(posedge Clk);
            #1;
            chk("bp_after_pop_inReady", {31'd0, inReady}, 32'd1);
            chk("bp_after_pop_outB", outB, 32'hAAAA_0002);
         end
      join
      drain();

      // Head-of-line: stalled A beat blocks a later C beat
      readyA = 1'b0;
      send(2'b00, 32'hA5A5_A5A5);
      send(2'b10, 32'hC3C3_C3C3);
      repeat (3) begin
         @(posedge Clk);
         #1;
         chk("hol_validC_blocked", {31'd0, validC}, 32'd0);
         chk("hol_validA", {31'd0, validA}, 32'd1);
      end
      readyA = 1'b1;
      @(posedge Clk);
      #1;
      chk("hol_validC_after", {31'd0, validC}, 32'd1);
      chk("hol_outC_after", outC, 32'hC3C3_C3C3);
      drain();

      // Illegal select: 300 beats, counter saturates
      inValid = 1'b1;
      inSel   = 2'b11;
      inData  = $urandom;
      for (int i = 0; i < 300; i++) begin
         @(posedge Clk);
         #1;
         inData = $urandom;
         if (i == 9)   chk("drop_10", {24'd0, dropCount}, 32'd10);
         if (i == 253) chk("drop_254", {24'd0, dropCount}, 32'd254);
         if (i == 254) chk("drop_255", {24'd0, dropCount}, 32'd255);
         if (i % 50 == 0) begin
            chk("drop_inReady", {31'd0, inReady}, 32'd1);
            chk("drop_valids", {29'd0, validC, validB, validA}, 32'd0);
         end
      end
      inValid = 1'b0;
      chk("drop_saturated", {24'd0, dropCount}, 32'd255);
      chk("drop_no_valid", {29'd0, validC, validB, validA}, 32'd0);

      // Push and pop in the same cycle: no bubble on A
      readyA = 1'b1;
      send(2'b00, 32'hB000_0001);
      chk("pp_outA_1", outA, 32'hB000_0001);
      send(2'b00, 32'hB000_0002);
      chk("pp_validA_2", {31'd0, validA}, 32'd1);
      chk("pp_outA_2", outA, 32'hB000_0002);
      send(2'b00, 32'hB000_0003);
      chk("pp_validA_3", {31'd0, validA}, 32'd1);
      chk("pp_outA_3", outA, 32'hB000_0003);
      chk("pp_inReady", {31'd0, inReady}, 32'd1);
      drain();

      // Async reset mid-stream with C full and stalled
      readyC = 1'b0;
      send(2'b10, 32'hCC00_0001);
      send(2'b10, 32'hCC00_0002);
      chk("ar_pre_inReady", {31'd0, inReady}, 32'd0);
      chk("ar_pre_validC", {31'd0, validC}, 32'd1);
      #2;
      Rst = 1'b1;
      #1;
      chk("ar_inReady", {31'd0, inReady}, 32'd1);
      chk("ar_valids", {29'd0, validC, validB, validA}, 32'd0);
      chk("ar_outC", outC, 32'd0);
      chk("ar_dropCount", {24'd0, dropCount}, 32'd0);
      #2;
      Rst = 1'b0;
      sb.delete();
      readyC = 1'b1;
      repeat (3) begin
         @(posedge Clk);
         #1;
         chk("ar_no_stale", {29'd0, validC, validB, validA}, 32'd0);
      end
      send(2'b10, 32'hCC00_0003);
      chk("ar_post_outC", outC, 32'hCC00_0003);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
